// File: rtl/uart_pkg.sv
// Shared constants for the oversampling UART receiver: FSM state codes and
// the 16x oversample sample points.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;
  localparam state_t ST_BRK    = 3'd5;

  localparam int OS_RATE = 16;

  localparam logic [3:0] OS_S0  = 4'd7;
  localparam logic [3:0] OS_S1  = 4'd8;
  localparam logic [3:0] OS_S2  = 4'd9;
  localparam logic [3:0] OS_END = 4'd15;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO for the UART receiver; a pop that coincides
// with a push while full lets both succeed.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [7:0]               i_din,
  input  logic                     i_pop,
  output logic [7:0]               o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = o_empty ? 8'h00 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push)
      r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)
        r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with majority voting and a receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with a sticky parity_err output.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              divisor,
  input  logic                     rx,
  input  logic                     rd,
  output logic [7:0]               dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     overrun,
`ifdef UART_RX_PARITY_EN
  output logic                     parity_err,
`endif
  input  logic                     clr_err
);

  localparam int OS_W = $clog2(OS_RATE);

`ifdef UART_RX_PARITY_EN
  localparam state_t ST_AFTER_DATA = ST_PARITY;
`else
  localparam state_t ST_AFTER_DATA = ST_STOP;
`endif

  logic            r_rx_meta;
  logic            r_rxs;
  state_t          r_state;
  logic [15:0]     r_div;
  logic [OS_W-1:0] r_os;
  logic            r_s0;
  logic            r_s1;
  logic [2:0]      r_bit;
  logic [7:0]      r_sh;
  logic            r_frame_err;
  logic            r_overrun;

  logic            w_tick;
  logic            w_maj;
  logic            w_mid;
  logic            w_end;
  logic            w_push;
  logic            w_stop_fail;
  logic            w_full;
  logic            w_empty;

`ifdef UART_RX_PARITY_EN
  logic            r_par_bad;
  logic            r_parity_err;
  logic            w_par_mis;
  assign w_par_mis  = w_maj ^ (^r_sh);
  assign parity_err = r_parity_err;
  assign w_push     = (r_state == ST_STOP) && w_mid && w_maj && !r_par_bad;
`else
  assign w_push     = (r_state == ST_STOP) && w_mid && w_maj;
`endif

  assign w_tick      = (r_state != ST_IDLE) && (r_div == divisor);
  assign w_maj       = maj3(r_s0, r_s1, r_rxs);
  assign w_mid       = w_tick && (r_os == OS_S2);
  assign w_end       = w_tick && (r_os == OS_END);
  assign w_stop_fail = (r_state == ST_STOP) && w_mid && !w_maj;

  assign busy      = (r_state != ST_IDLE);
  assign valid     = !w_empty;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
    end
  end

  // Counters idle at zero so a new frame always starts aligned to the start edge.
  always_ff @(posedge clk) begin
    if (rst || r_state == ST_IDLE) begin
      r_div <= '0;
      r_os  <= '0;
      r_s0  <= 1'b1;
      r_s1  <= 1'b1;
    end else if (w_tick) begin
      r_div <= '0;
      r_os  <= r_os + 1'b1;
      if (r_os == OS_S0)
        r_s0 <= r_rxs;
      if (r_os == OS_S1)
        r_s1 <= r_rxs;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_bit   <= '0;
      r_sh    <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE:
          if (!r_rxs)
            r_state <= ST_START;
        ST_START:
          if (w_mid && w_maj)
            r_state <= ST_IDLE;
          else if (w_end) begin
            r_state <= ST_DATA;
            r_bit   <= '0;
          end
        ST_DATA: begin
          if (w_mid)
            r_sh <= {w_maj, r_sh[7:1]};
          if (w_end) begin
            r_bit <= r_bit + 1'b1;
            if (r_bit == 3'd7)
              r_state <= ST_AFTER_DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_mid)
            r_par_bad <= w_par_mis;
          if (w_end)
            r_state <= ST_STOP;
        end
`endif
        // Stop decision is taken mid-bit so back-to-back frames are never missed.
        ST_STOP:
          if (w_mid)
            r_state <= w_maj ? ST_IDLE : ST_BRK;
        ST_BRK:
          if (r_rxs)
            r_state <= ST_IDLE;
        default:
          r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (w_stop_fail)
        r_frame_err <= 1'b1;
      else if (clr_err)
        r_frame_err <= 1'b0;
      if (w_push && w_full && !rd)
        r_overrun <= 1'b1;
      else if (clr_err)
        r_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if ((r_state == ST_PARITY) && w_mid && w_par_mis)
        r_parity_err <= 1'b1;
      else if (clr_err)
        r_parity_err <= 1'b0;
`endif
    end
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (r_sh),
    .i_pop   (rd),
    .o_dout  (dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frames are generated bit by bit and a queue
// model, fed with frame-level events at their computed cycles, is checked every cycle.
module tb_uart_rx_os;

  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int STOP_IDX = 9 + NPAR;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] divisor = 16'd0;
  logic        rx = 1'b1;
  logic        rd = 1'b0;
  logic        clr_err = 1'b0;
  logic [7:0]  dout;
  logic        valid;
  logic [$clog2(DEPTH):0] level;
  logic        busy;
  logic        frame_err;
  logic        overrun;
`ifdef UART_RX_PARITY_EN
  logic        parity_err;
`endif

  always #5 clk = ~clk;

  uart_rx_os #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .divisor    (divisor),
    .rx         (rx),
    .rd         (rd),
    .dout       (dout),
    .valid      (valid),
    .level      (level),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .clr_err    (clr_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model state: byte queue, sticky flags, and the one scheduled frame outcome.
  logic [7:0] mq[$];
  bit         m_ferr, m_ovr, m_perr;
  int         s_cyc = -1;
  int         s_kind = 0;
  logic [7:0] s_data = 8'h00;
  int         p_cyc = -1;
  bit         m_push;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      mq.delete();
      m_ferr = 0; m_ovr = 0; m_perr = 0;
      s_kind = 0; p_cyc = -1;
    end else begin
      if (clr_err) begin m_ferr = 0; m_ovr = 0; m_perr = 0; end
      if (s_kind == 2 && cyc == s_cyc) m_ferr = 1;
      if (cyc == p_cyc) m_perr = 1;
      m_push = (s_kind == 1 && cyc == s_cyc);
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back(s_data);
        else m_ovr = 1;
      end
    end
  end

  logic [7:0] e_dout;
  logic       e_valid;
  int         e_lvl;
  bit         e_perr, a_perr;

  always @(negedge clk) begin
    e_lvl   = mq.size();
    e_valid = (e_lvl > 0);
    e_dout  = e_valid ? mq[0] : 8'h00;
`ifdef UART_RX_PARITY_EN
    a_perr = parity_err;
`else
    a_perr = 1'b0;
`endif
    e_perr = m_perr;
    n_vec++;
    if (dout !== e_dout || valid !== e_valid || int'(level) != e_lvl || $isunknown(level) ||
        frame_err !== m_ferr || overrun !== m_ovr || a_perr !== e_perr) begin
      n_err++;
      $display("FAIL model cyc=%0d got dout=%h valid=%b level=%0d ferr=%b ovr=%b perr=%b exp dout=%h valid=%b level=%0d ferr=%b ovr=%b perr=%b",
               cyc, dout, valid, level, frame_err, overrun, a_perr,
               e_dout, e_valid, e_lvl, m_ferr, m_ovr, e_perr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rx = 1'b1; rd = 1'b0; clr_err = 1'b0;
    repeat (3) tick_clk();
    rst = 1'b0;
    tick_clk();
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check(name, {31'd0, valid}, 32'd1);
    check(name, {24'd0, dout}, {24'd0, exp});
    rd = 1'b1;
    tick_clk();
    rd = 1'b0;
  endtask

  // Drive one frame; stop_low>0 holds the line low that many bit times from the stop bit.
  task automatic send(input logic [7:0] data, input int stop_low, input bit rd_at_push,
                      input bit bad_par, input int abort_bit);
    int p, bt, tot, k, b;
    logic v;
    p   = int'(divisor) + 1;
    bt  = 16 * p;
    k   = cyc;
    tot = (STOP_IDX + 1 + stop_low + 2) * bt;
    s_data = data;
    s_cyc  = k + 3 + p * (16 * STOP_IDX + 10);
    s_kind = (stop_low > 0) ? 2 : ((bad_par && NPAR == 1) ? 0 : 1);
    p_cyc  = (bad_par && NPAR == 1) ? (k + 3 + p * (16 * 9 + 10)) : -1;
    for (int t = 0; t < tot; t++) begin
      b = t / bt;
      if (b == 0) v = 1'b0;
      else if (b <= 8) v = data[b-1];
      else if (b < STOP_IDX) v = (^data) ^ bad_par;
      else if (b < STOP_IDX + stop_low) v = 1'b0;
      else v = 1'b1;
      rx = v;
      if (rd_at_push) rd = (cyc == s_cyc - 1);
      clr_err = 1'b0;
      if (stop_low > 0 && t == (STOP_IDX + 20) * bt) begin
        check("ferr_set_in_break", {31'd0, frame_err}, 32'd1);
        clr_err = 1'b1;
      end
      if (abort_bit >= 0 && t == abort_bit * bt + bt / 2) begin
        rst = 1'b1; rx = 1'b1;
        tick_clk();
        tick_clk();
        rst = 1'b0;
        tick_clk();
        return;
      end
      tick_clk();
    end
    rd = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_dout",  {24'd0, dout}, 32'h00);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_ferr",  {31'd0, frame_err}, 32'd0);
    check("rst_ovr",   {31'd0, overrun}, 32'd0);

    // Single byte at 16 clocks per bit.
    send(8'hA5, 0, 1'b0, 1'b0, -1);
    check("a5_level", 32'(level), 32'd1);
    pop_check("a5_dout", 8'hA5);
    check("a5_empty_valid", {31'd0, valid}, 32'd0);
    check("a5_empty_dout", {24'd0, dout}, 32'h00);

    // Four-clock glitch: busy after 3 clocks, false start rejected at os=9.
    rx = 1'b0;
    tick_clk(); tick_clk();
    check("busy_lat2", {31'd0, busy}, 32'd0);
    tick_clk();
    check("busy_lat3", {31'd0, busy}, 32'd1);
    tick_clk();
    rx = 1'b1;
    repeat (8) tick_clk();
    check("glitch_busy_pre", {31'd0, busy}, 32'd1);
    tick_clk();
    check("glitch_idle", {31'd0, busy}, 32'd0);
    check("glitch_level", 32'(level), 32'd0);
    check("glitch_ferr", {31'd0, frame_err}, 32'd0);

    // Long break after a byte: one frame error, nothing queued, no re-framing.
    send(8'h3C, 40, 1'b0, 1'b0, -1);
    check("brk_ferr_cleared", {31'd0, frame_err}, 32'd0);
    check("brk_level", 32'(level), 32'd0);
    check("brk_busy", {31'd0, busy}, 32'd0);

    // Overrun: fifth byte dropped.
    do_reset();
    for (int i = 1; i <= 5; i++) send(8'(i), 0, 1'b0, 1'b0, -1);
    check("ovr_level", 32'(level), 32'd4);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    for (int i = 1; i <= 4; i++) pop_check("ovr_read", 8'(i));
    check("ovr_drained", {31'd0, valid}, 32'd0);
    clr_err = 1'b1; tick_clk(); clr_err = 1'b0;
    check("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Full FIFO, push coincides with rd: no overrun, order ends 04, 05.
    for (int i = 1; i <= 4; i++) send(8'(i), 0, 1'b0, 1'b0, -1);
    send(8'h05, 0, 1'b1, 1'b0, -1);
    check("coin_ovr", {31'd0, overrun}, 32'd0);
    check("coin_level", 32'(level), 32'd4);
    for (int i = 2; i <= 5; i++) pop_check("coin_read", 8'(i));

    // Reset during data bit 3 aborts the frame and empties the FIFO.
    send(8'h77, 0, 1'b0, 1'b0, -1);
    check("pre_abort_level", 32'(level), 32'd1);
    send(8'hC3, 0, 1'b0, 1'b0, 4);
    check("abort_valid", {31'd0, valid}, 32'd0);
    check("abort_dout", {24'd0, dout}, 32'h00);
    check("abort_level", 32'(level), 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    divisor = 16'd1;
    send(8'h5A, 0, 1'b0, 1'b0, -1);
    check("post_abort_level", 32'(level), 32'd1);
    pop_check("post_abort_dout", 8'h5A);

`ifdef UART_RX_PARITY_EN
    divisor = 16'd0;
    send(8'h96, 0, 1'b0, 1'b1, -1);
    check("par_err", {31'd0, parity_err}, 32'd1);
    check("par_level", 32'(level), 32'd0);
    clr_err = 1'b1; tick_clk(); clr_err = 1'b0;
    check("par_cleared", {31'd0, parity_err}, 32'd0);
`endif

    repeat (4) tick_clk();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver with a receive FIFO, the receive-side counterpart of the serial port's simple transmitter. Samples `rx` at 16x the bit rate, validates the start bit, majority-votes each bit, checks the stop bit, and queues good bytes into a small first-word-fall-through FIFO. Reports framing and overrun errors. Sits between the RX pin and the SerialPorts bus register file.

## Interface
- `DEPTH`, default 4: FIFO depth in bytes; power of two, minimum 2.
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `divisor` in 16: oversample tick period minus one, giving a bit period of 16*(divisor+1) clocks. Sampled live; change it only while `busy`=0.
- `rx` in 1: serial input, asynchronous, idle high.
- `rd` in 1: pop the FIFO head; ignored when empty.
- `dout` out 8: FIFO head when `valid`=1, otherwise 8'h00.
- `valid` out 1: FIFO not empty.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.
- `busy` out 1: frame in progress (state ≠ IDLE).
- `frame_err` out 1: sticky; stop bit sampled low.
- `overrun` out 1: sticky; a good byte was dropped because the FIFO was full.
- `clr_err` in 1: clears `frame_err`, `overrun` (and `parity_err` when configured).

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rxs`. All decisions use `rxs`.
- Tick counter: counts 0..`divisor`, pulses `tick` at `divisor`, then wraps to 0. The counter is held at 0 in IDLE.
- Oversample counter `os` (4 bits) advances on each `tick` and wraps 15→0 at each bit boundary.
- Majority sampling: `rxs` is captured on the ticks where `os`=7, 8, 9. The bit value is the 2-of-3 majority, decided on the `os`=9 tick.
- States and transitions:
  - IDLE → START when `rxs`=0. On entry, `os` and the tick counter are zeroed.
  - START: if the majority is 1, the start is false and the FSM returns to IDLE at `os`=9. If the majority is 0, the FSM moves to DATA at the `os`=15 tick.
  - DATA: 8 bits, LSB first, shifted into `sh[7:0]`. After the eighth bit, at `os`=15, the FSM moves to STOP (or PARITY when configured).
  - STOP: the decision is made at `os`=9.
    - Majority 1: push `sh` and return to IDLE immediately, with no wait for the end of the stop bit.
    - Majority 0: set `frame_err`, discard the byte, and go to BRK.
  - BRK: wait for `rxs`=1, then go to IDLE. This prevents a line break from producing repeated frames.
- FIFO rules:
  - Push while full with no `rd` in the same cycle: byte dropped, `overrun` set.
  - Push and `rd` in the same cycle while full: both succeed, no overrun, `level` unchanged.
  - `rd` while empty: no effect.
- Sticky flags: if a set event and `clr_err` occur in the same cycle, the set wins.
- Reset values: `dout`=0, `valid`=0, `level`=0, `busy`=0, `frame_err`=0, `overrun`=0; state IDLE; pointers 0.
- Reset mid-frame aborts the frame and empties the FIFO.

## Timing
- From a falling edge on `rx` to `busy`=1: 3 clocks (2 synchronizer stages + the IDLE→START register).
- A push takes effect on the clock edge of the STOP decision tick. `valid` and `level` update on that same edge.
- `dout` is combinational from FIFO memory and the read pointer. A `rd` presents the next entry the cycle after the edge on which it is sampled.
- The minimum glitch rejected is anything shorter than about 8 ticks (majority of samples 7–9).

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: adds a PARITY state between DATA and STOP that samples one even-parity bit. A mismatch sets a sticky `parity_err` output (cleared by `clr_err`) and the byte is discarded.
  - Not defined: frames are 8N1, the `parity_err` port is absent, and DATA goes directly to STOP.

## Structure
- `uart_pkg`: state enum (IDLE, START, DATA, PARITY, STOP, BRK), `OS_RATE`=16, and sample indices `OS_S0`=7, `OS_S1`=8, `OS_S2`=9, `OS_END`=15.
- Sub-module `uart_rx_fifo`: synchronous FWFT FIFO parameterized by `DEPTH`, with push, pop, full, empty and level. The parent holds the FSM, tick generator, synchronizer and flags.

## Test plan
- `divisor`=0 (16 clk/bit), send 8N1 byte 8'hA5 → `valid`=1, `dout`=8'hA5, `level`=1; `rd` → `valid`=0, `dout`=8'h00.
- 4-clock low glitch on idle `rx` → returns to IDLE at the START `os`=9 tick, `level` stays 0, no flags set.
- Byte 8'h3C with the stop bit held low for 40 bit times → `frame_err`=1, FIFO empty, exactly one frame observed; `clr_err` → `frame_err`=0.
- `DEPTH`=4, send 8'h01..8'h05 with no `rd` → `level`=4, `overrun`=1, reads return 01, 02, 03, 04.
- FIFO full, fifth byte's push coincides with `rd` → `overrun`=0, `level`=4, and the FIFO order ends ...04, 05.
- `rst` asserted during DATA bit 3 → all outputs at reset values; a following byte 8'h5A is received correctly. With `UART_RX_PARITY_EN`, a bad parity bit sets `parity_err` and nothing is pushed.
